// File: rtl/pool_layer_sequencer.sv
// Layer controller for the max-pooling engine: per-channel engine reset,
// row-major pixel streaming, and output addressing with a drain timeout.
module pool_layer_sequencer #(
   parameter int M         = 4,
   parameter int P         = 2,
   parameter int C         = 4,
   parameter int AW        = 16,
   parameter int DRAIN_MAX = 64
) (
   input  logic          clk,
   input  logic          master_rst,
   input  logic          start,
   input  logic [AW-1:0] in_base,
   input  logic [AW-1:0] out_base,
   input  logic          hold,
   input  logic          pool_valid,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          pool_rst,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic          pool_ce,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr
);

   localparam int NPIX = M * M;
   localparam int NOUT = (M / P) * (M / P);
   localparam int PW   = $clog2(NPIX);
   localparam int OW   = $clog2(NOUT + 1);
   localparam int CW   = (C > 1) ? $clog2(C) : 1;
   localparam int DW   = $clog2(DRAIN_MAX + 1);

   localparam logic [AW-1:0] CH_IN   = AW'(NPIX);
   localparam logic [AW-1:0] CH_OUT  = AW'(NOUT);
   localparam logic [PW-1:0] PIX_END = PW'(NPIX - 1);
   localparam logic [OW-1:0] OUT_END = OW'(NOUT);
   localparam logic [CW-1:0] CH_END  = CW'(C - 1);
   localparam logic [DW-1:0] DRN_END = DW'(DRAIN_MAX);

   typedef enum logic [2:0] {
      S_IDLE, S_CH_RST, S_STREAM, S_DRAIN, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pix_q, pix_d;
   logic [OW-1:0] out_q, out_d;
   logic [CW-1:0] ch_q, ch_d;
   logic [DW-1:0] drn_q, drn_d;
   logic [AW-1:0] ibase_q, ibase_d;
   logic [AW-1:0] obase_q, obase_d;
   logic          err_q, err_d;
   logic          busy_q, done_q, prst_q, ce_q;
   logic          active;
   logic [AW-1:0] ch_a;

   assign active = (state_q == S_STREAM) || (state_q == S_DRAIN);
   assign ch_a   = AW'(ch_q);

   assign rd_en   = (state_q == S_STREAM) && !hold;
   assign rd_addr = (state_q == S_STREAM) ?
                    ibase_q + ch_a * CH_IN + AW'(pix_q) : '0;
   assign wr_en   = pool_valid && active && (out_q < OUT_END);
   assign wr_addr = obase_q + ch_a * CH_OUT + AW'(out_q);

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign pool_rst = prst_q;
   assign pool_ce  = ce_q;

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      out_d   = out_q;
      ch_d    = ch_q;
      drn_d   = drn_q;
      ibase_d = ibase_q;
      obase_d = obase_q;
      err_d   = err_q;

      if (wr_en) out_d = out_q + 1'b1;
      // A result beyond the channel's quota is dropped but flagged.
      if (pool_valid && active && (out_q == OUT_END)) err_d = 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               ibase_d = in_base;
               obase_d = out_base;
               ch_d    = '0;
               err_d   = 1'b0;
               state_d = S_CH_RST;
            end
         end
         S_CH_RST: begin
            pix_d   = '0;
            out_d   = '0;
            drn_d   = '0;
            state_d = S_STREAM;
         end
         S_STREAM: begin
            if (rd_en) begin
               if (pix_q == PIX_END) begin
                  pix_d   = '0;
                  state_d = S_DRAIN;
               end else begin
                  pix_d = pix_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            drn_d = drn_q + 1'b1;
            if (out_d == OUT_END) begin
               if (ch_q == CH_END) begin
                  state_d = S_DONE;
               end else begin
                  ch_d    = ch_q + 1'b1;
                  state_d = S_CH_RST;
               end
            end else if (drn_d == DRN_END) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge master_rst) begin
      if (master_rst) begin
         state_q <= S_IDLE;
         pix_q   <= '0;
         out_q   <= '0;
         ch_q    <= '0;
         drn_q   <= '0;
         ibase_q <= '0;
         obase_q <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         prst_q  <= 1'b0;
         ce_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         out_q   <= out_d;
         ch_q    <= ch_d;
         drn_q   <= drn_d;
         ibase_q <= ibase_d;
         obase_q <= obase_d;
         err_q   <= err_d;
         busy_q  <= (state_d == S_CH_RST) || (state_d == S_STREAM) ||
                    (state_d == S_DRAIN);
         done_q  <= (state_d == S_DONE);
         prst_q  <= (state_d == S_CH_RST);
         ce_q    <= rd_en;
      end
   end

endmodule

// File: tb/tb_pool_layer_sequencer.sv
// Scoreboard bench for pool_layer_sequencer with a small pooling-engine
// model that answers two cycles after every fourth clock enable.
module tb_pool_layer_sequencer;

   localparam int M    = 4;
   localparam int P    = 2;
   localparam int C    = 4;
   localparam int AW   = 16;
   localparam int NPIX = M * M;
   localparam int NOUT = (M / P) * (M / P);

   logic          clk = 1'b0;
   logic          master_rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] in_base = '0;
   logic [AW-1:0] out_base = '0;
   logic          hold = 1'b0;
   logic          pool_valid = 1'b0;
   logic          busy, done, err, pool_rst, rd_en, pool_ce, wr_en;
   logic [AW-1:0] rd_addr, wr_addr;

   pool_layer_sequencer #(
      .M(M), .P(P), .C(C), .AW(AW), .DRAIN_MAX(64)
   ) dut (
      .clk(clk), .master_rst(master_rst), .start(start),
      .in_base(in_base), .out_base(out_base), .hold(hold),
      .pool_valid(pool_valid), .busy(busy), .done(done), .err(err),
      .pool_rst(pool_rst), .rd_en(rd_en), .rd_addr(rd_addr),
      .pool_ce(pool_ce), .wr_en(wr_en), .wr_addr(wr_addr)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   logic [AW-1:0] rdq[$];
   logic [AW-1:0] wrq[$];
   int   cyc = 0;
   int   t0 = 1000000;
   int   n_rst, n_done, n_wr;
   int   ce_n = 0;
   logic [1:0] pipe = 2'b00;
   logic inj = 1'b0;
   logic model_on = 1'b1;
   logic skip4 = 1'b0;
   logic t1_on = 1'b0;

   // Engine response is driven late in the cycle's first half.
   always @(posedge clk) begin
      cyc++;
      #2;
      pool_valid = pipe[1] | inj;
   end

   always @(negedge clk) begin : mon
      int rel;
      logic ev;
      logic [31:0] e;
      rel = cyc - t0 + 1;
      if (master_rst || pool_rst) ce_n = 0;
      ev = 1'b0;
      if (pool_ce) begin
         ce_n++;
         ev = model_on && (ce_n % 4 == 0) && !(skip4 && ce_n == NPIX);
      end
      pipe = master_rst ? 2'b00 : {pipe[0], ev};
      if (rd_en) begin
         if (rdq.size() > 0) e = {16'h0, rdq.pop_front()};
         else e = 32'hDEAD_BEEF;
         check("rd_addr", {16'h0, rd_addr}, e);
      end
      if (wr_en) begin
         if (wrq.size() > 0) e = {16'h0, wrq.pop_front()};
         else e = 32'hDEAD_BEEF;
         check("wr_addr", {16'h0, wr_addr}, e);
      end
      n_rst  += int'(pool_rst);
      n_done += int'(done);
      n_wr   += int'(wr_en);
      if (t1_on) begin
         if (rel == 1) check("c1_pool_rst", pool_rst, 1);
         if (rel == 1) check("c1_rd_en", rd_en, 0);
         if (rel == 2) check("c2_rd_en", rd_en, 1);
         if (rel == 2) check("c2_pool_ce", pool_ce, 0);
         if (rel == 3) check("c3_pool_ce", pool_ce, 1);
         if (rel == 17) check("c17_rd_addr", rd_addr, 16'h010F);
         if (rel == 18) check("c18_rd_en", rd_en, 0);
         if (rel == 18) check("c18_pool_ce", pool_ce, 1);
         if (rel == 19) check("c19_pool_ce", pool_ce, 0);
         if (rel == 21) check("c21_pool_rst", pool_rst, 1);
      end
   end

   task automatic push_rd(input logic [AW-1:0] ib, input int ch);
      for (int i = 0; i < NPIX; i++) rdq.push_back(ib + AW'(ch * NPIX + i));
   endtask

   task automatic push_wr(input logic [AW-1:0] ob, input int ch,
                          input int n);
      for (int i = 0; i < n; i++) wrq.push_back(ob + AW'(ch * NOUT + i));
   endtask

   task automatic go(input logic [AW-1:0] ib, input logic [AW-1:0] ob);
      @(posedge clk);
      #1;
      t0 = cyc + 1000000;
      n_rst = 0; n_done = 0; n_wr = 0;
      start = 1'b1; in_base = ib; out_base = ob;
      @(posedge clk);
      #1;
      t0 = cyc;
      start = 1'b0; in_base = 16'hEEEE; out_base = 16'hDDDD;
   endtask

   task automatic at_rel(input int r);
      while (cyc - t0 + 1 < r) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input int exp_rel, input int budget);
      int got;
      got = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            got = cyc - t0 + 1;
            break;
         end
      end
      check("done_cycle", got, exp_rel);
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_rdq_left"}, rdq.size(), 0);
      check({tag, "_wrq_left"}, wrq.size(), 0);
   endtask

   initial begin
      #1;
      check("rst_ctl", {busy, done, err, pool_rst, rd_en, pool_ce, wr_en}, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_wr_addr", wr_addr, 0);
      repeat (2) @(posedge clk);
      #1 master_rst = 1'b0;

      // Stray engine result while idle
      @(posedge clk);
      #1 inj = 1'b1;
      @(negedge clk);
      check("idle_pv_wr_en", wr_en, 0);
      @(posedge clk);
      #1 inj = 1'b0;
      @(negedge clk);
      check("idle_pv_err", err, 0);

      // Full layer, plus a start coinciding with done
      for (int c = 0; c < C; c++) begin
         push_rd(16'h0100, c);
         push_wr(16'h0200, c, NOUT);
      end
      t1_on = 1'b1;
      go(16'h0100, 16'h0200);
      at_rel(81);
      start = 1'b1;
      wait_done(81, 200);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("start_at_done_busy82", busy, 0);
      @(negedge clk);
      check("start_at_done_busy83", busy, 0);
      t1_on = 1'b0;
      check("full_pool_rst_cnt", n_rst, C);
      check("full_wr_cnt", n_wr, C * NOUT);
      check("full_done_cnt", n_done, 1);
      check("full_err", err, 0);
      check_empty("full");

      // Hold for three cycles at pixel 5; start while busy at cycle 10
      for (int c = 0; c < C; c++) begin
         push_rd(16'h0100, c);
         push_wr(16'h0200, c, NOUT);
      end
      go(16'h0100, 16'h0200);
      at_rel(7);
      hold = 1'b1;
      @(negedge clk);
      check("hold7_rd_en", rd_en, 0);
      check("hold7_rd_addr", rd_addr, 16'h0105);
      check("hold7_ce", pool_ce, 1);
      at_rel(8);
      @(negedge clk);
      check("hold8_rd_en", rd_en, 0);
      check("hold8_rd_addr", rd_addr, 16'h0105);
      check("hold8_ce", pool_ce, 0);
      at_rel(9);
      @(negedge clk);
      check("hold9_rd_en", rd_en, 0);
      check("hold9_ce", pool_ce, 0);
      at_rel(10);
      hold = 1'b0;
      start = 1'b1; in_base = 16'h0700; out_base = 16'h0900;
      @(negedge clk);
      check("hold10_rd_en", rd_en, 1);
      check("hold10_rd_addr", rd_addr, 16'h0105);
      check("hold10_ce", pool_ce, 0);
      at_rel(11);
      start = 1'b0;
      @(negedge clk);
      check("hold11_ce", pool_ce, 1);
      check("busy_start_ign", busy, 1);
      wait_done(84, 200);
      check("hold_wr_cnt", n_wr, C * NOUT);
      check("hold_err", err, 0);
      check_empty("hold");

      // Fourth result of channel 0 never arrives
      skip4 = 1'b1;
      push_rd(16'h0100, 0);
      push_wr(16'h0200, 0, NOUT - 1);
      go(16'h0100, 16'h0200);
      wait_done(82, 300);
      check("tmo_err", err, 1);
      check("tmo_pool_rst_cnt", n_rst, 1);
      skip4 = 1'b0;
      @(negedge clk);
      check("tmo_idle_busy", busy, 0);
      check_empty("tmo");

      // One result too many within channel 0
      model_on = 1'b0;
      push_rd(16'h0100, 0);
      push_rd(16'h0100, 1);
      push_wr(16'h0200, 0, NOUT);
      go(16'h0100, 16'h0200);
      @(negedge clk);
      check("err_cleared", err, 0);
      at_rel(4);
      inj = 1'b1;
      at_rel(8);
      @(negedge clk);
      check("xtra_wr_en", wr_en, 0);
      check("xtra_err_pre", err, 0);
      at_rel(9);
      inj = 1'b0;
      @(negedge clk);
      check("xtra_err", err, 1);
      wait_done(100, 300);
      check("xtra_wr_cnt", n_wr, NOUT);
      check("xtra_pool_rst_cnt", n_rst, 2);
      model_on = 1'b1;
      check_empty("xtra");

      // Asynchronous abort at cycle 8, then a clean rerun
      push_rd(16'h0100, 0);
      go(16'h0100, 16'h0200);
      at_rel(8);
      master_rst = 1'b1;
      #2;
      check("abort_ctl", {busy, done, err, pool_rst, rd_en, pool_ce, wr_en},
            0);
      check("abort_rd_addr", rd_addr, 0);
      check("abort_wr_addr", wr_addr, 0);
      @(negedge clk);
      check("abort_busy", busy, 0);
      @(posedge clk);
      #1 master_rst = 1'b0;
      rdq.delete();
      wrq.delete();
      for (int c = 0; c < C; c++) begin
         push_rd(16'h0100, c);
         push_wr(16'h0200, c, NOUT);
      end
      go(16'h0100, 16'h0200);
      wait_done(81, 200);
      check("rerun_wr_cnt", n_wr, C * NOUT);
      check("rerun_pool_rst_cnt", n_rst, C);
      check("rerun_err", err, 0);
      repeat (3) @(negedge clk);
      check("rerun_done_cnt", n_done, 1);
      check_empty("rerun");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pool_layer_sequencer.md
# pool_layer_sequencer

Layer-level controller for the max-pooling engine. Runs one pooling layer over C channels of M×M feature maps. For each channel it resets the engine, streams the channel's pixels in row-major order from input feature-map memory, and gives each pooled result its output-memory address. A start/busy/done handshake connects it to the top-level layer scheduler.

## Interface
Parameters:
- M, 4: feature-map width and height in pixels. Must be a multiple of P.
- P, 2: pooling window size, ≥2.
- C, 4: number of channels per layer, ≥1.
- AW, 16: memory address width.
- DRAIN_MAX, 64: cycle limit for the DRAIN state before the layer is aborted.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- master_rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to run a layer. Ignored while busy=1.
- in_base  in  AW  base address of channel 0 input. Sampled when start is accepted.
- out_base  in  AW  base address of channel 0 output. Sampled when start is accepted.
- hold  in  1  stalls pixel issue while high.
- pool_valid  in  1  the engine presents one pooled result this cycle.
- busy  out  1  layer in progress.
- done  out  1  single-cycle pulse at layer end.
- err  out  1  sticky error flag. Cleared when the next start is accepted.
- pool_rst  out  1  synchronous reset to the engine, one cycle per channel.
- rd_en  out  1  input-memory read strobe.
- rd_addr  out  AW  input-memory read address.
- pool_ce  out  1  engine clock enable, equal to rd_en delayed one cycle (memory read latency is 1).
- wr_en  out  1  output-memory write strobe, combinational.
- wr_addr  out  AW  output-memory write address.

## Operation
- Derived constants: NPIX = M*M, NOUT = (M/P)², CH_IN = NPIX, CH_OUT = NOUT.
- Counters: pix_cnt (0..NPIX-1), out_cnt (0..NOUT), ch (0..C-1), drain_cnt (0..DRAIN_MAX).
- Address arithmetic is modulo 2^AW; overflow wraps silently.
- State IDLE:
  - busy=0.
  - On start: latch in_base and out_base, set ch=0, clear err, go to CH_RST.
- State CH_RST:
  - pool_rst=1 for one cycle.
  - Clear pix_cnt and out_cnt.
  - Go to STREAM.
- State STREAM:
  - When hold=0: rd_en=1, rd_addr = in_base + ch*CH_IN + pix_cnt, then pix_cnt increments.
  - When hold=1: rd_en=0 and pix_cnt holds.
  - Issuing pixel NPIX-1 moves to DRAIN.
- State DRAIN:
  - drain_cnt increments every cycle.
  - If out_cnt reaches NOUT (including a pool_valid arriving this cycle): go to DONE when ch==C-1, otherwise increment ch and go to CH_RST.
  - If drain_cnt reaches DRAIN_MAX first: set err=1 and go to DONE, abandoning the remaining channels.
- State DONE:
  - done=1 and busy=0 for one cycle.
  - Go to IDLE.
- busy=1 in CH_RST, STREAM and DRAIN.
- Output path:
  - wr_en = pool_valid & (state is STREAM or DRAIN) & (out_cnt < NOUT).
  - wr_addr = out_base + ch*CH_OUT + out_cnt.
  - out_cnt increments on every wr_en.
- Boundary cases:
  - pool_valid when out_cnt==NOUT: no write, err=1.
  - pool_valid in IDLE, CH_RST or DONE: ignored. No write, no err.
  - hold is ignored outside STREAM.
  - start during busy has no effect.
  - start in the same cycle as done: ignored, because the FSM is in DONE, not IDLE.

## Timing
- Reset values: every output is 0. State=IDLE and all counters are 0. pool_ce's delay register is cleared.
- Asserting master_rst mid-layer aborts immediately and asynchronously. No done pulse is generated and memory contents are left as they are.
- Cycle numbering for a start accepted at edge 0:
  - CH_RST (pool_rst=1) at cycle 1.
  - First rd_en at cycle 2, first pool_ce at cycle 3.
  - With no hold, the last rd_en is at cycle NPIX+1 and the last pool_ce at cycle NPIX+2.
- Channel turnaround: DRAIN exit → CH_RST → next STREAM, so the per-channel overhead is 2 cycles plus the drain wait.
- pool_ce follows rd_en delayed one cycle even when hold toggles, so a one-cycle ce bubble appears exactly one cycle after each hold cycle.
- done occurs exactly one cycle after the DRAIN exit condition on the last channel, or after the timeout.

## Test plan
- **Single channel** (M=4, P=2, C=1, in_base=0x100, out_base=0x200). Engine model returns a pool_valid 2 cycles after every 4th ce.
  - Required: pool_rst at cycle 1; rd_addr 0x100..0x10F on cycles 2..17; pool_ce on cycles 3..18; wr_addr 0x200..0x203; exactly one done pulse; err=0.
- **Four channels** (C=4, same bases).
  - Required: channel 3 reads 0x130..0x13F and writes 0x20C..0x20F; four pool_rst pulses; 16 writes in total; done once.
- **Hold** asserted for 3 cycles while pix_cnt=5.
  - Required: rd_addr stays at 0x105 with rd_en=0 for those 3 cycles; pool_ce shows a 3-cycle gap shifted by one cycle; address sequence otherwise unchanged.
- **Drain timeout**: model withholds the 4th pool_valid (DRAIN_MAX=64).
  - Required: after 64 DRAIN cycles, err=1 and done pulses; channels 1..C-1 are never read.
  - An extra pool_valid after the 4th write gives wr_en=0 and err=1.
- **Start while busy and mid-layer reset**:
  - start pulsed at cycle 10 is ignored; addresses are unchanged.
  - master_rst at cycle 8: all outputs go to 0 immediately and the FSM is in IDLE. A new start then runs cleanly from channel 0.
